// File: rtl/register_file.sv
// 32 x 32-bit register file for the multicycle MIPS datapath: two combinational
// read ports with optional write-through bypass, one synchronous write port, $0 hardwired to zero.
package register_file_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;
endpackage

// One read port: 32:1 array mux, $0 forced to zero, same-cycle write forwarding.
module register_file_rd_port
  import register_file_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic [DEPTH-1:0][DW-1:0] regs,
  input  wr_req_t                  wr,
  input  logic [AW-1:0]            addr,
  output logic [DW-1:0]            data
);
  always_comb begin
    data = regs[addr];
    if (addr == '0)
      data = '0;
    else if ((BYPASS != 0) && wr.en && (wr.addr == addr))
      data = wr.data;
  end
endmodule

module register_file
  import register_file_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter int          BYPASS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Read_register_1,
  input  logic [4:0]  Read_register_2,
  input  logic [4:0]  Write_register,
  input  logic [31:0] Write_data,
  input  logic        RegWrite,
  output logic [31:0] Read_data_1,
  output logic [31:0] Read_data_2
);
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DW-1:0]     mem;
  logic [NUM_PORTS-1:0][AW-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DW-1:0] rd_data;
  wr_req_t                      wr;

  // Reset masks the write so it is neither stored nor forwarded.
  assign wr.en   = RegWrite & ~reset;
  assign wr.addr = Write_register;
  assign wr.data = Write_data;

  assign rd_addr[0]  = Read_register_1;
  assign rd_addr[1]  = Read_register_2;
  assign Read_data_1 = rd_data[0];
  assign Read_data_2 = rd_data[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem     <= '0;
      mem[28] <= GP_INIT;
      mem[29] <= SP_INIT;
    end else if (wr.en && (wr.addr != '0)) begin
      mem[wr.addr] <= wr.data;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
      register_file_rd_port #(.BYPASS(BYPASS)) u_rd (
        .regs (mem),
        .wr   (wr),
        .addr (rd_addr[p]),
        .data (rd_data[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: one bypassing and one non-bypassing register_file share the
// same stimulus and are checked against an array model of the register file.
module tb_register_file;
  localparam logic [31:0] SP = 32'h0000_3FFC;
  localparam logic [31:0] GP = 32'h0000_1800;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  Read_register_1 = '0, Read_register_2 = '0, Write_register = '0;
  logic [31:0] Write_data = '0;
  logic        RegWrite = 1'b0;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_q [32];

  always #5 clk = ~clk;

  register_file #(.SP_INIT(SP), .GP_INIT(GP), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset),
    .Read_register_1(Read_register_1), .Read_register_2(Read_register_2),
    .Write_register(Write_register), .Write_data(Write_data), .RegWrite(RegWrite),
    .Read_data_1(b_rd1), .Read_data_2(b_rd2)
  );

  register_file #(.SP_INIT(SP), .GP_INIT(GP), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset),
    .Read_register_1(Read_register_1), .Read_register_2(Read_register_2),
    .Write_register(Write_register), .Write_data(Write_data), .RegWrite(RegWrite),
    .Read_data_1(n_rd1), .Read_data_2(n_rd2)
  );

  // Reference contents: what each architectural register holds after every edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ref_q[i] <= (i == 28) ? GP : (i == 29) ? SP : 32'h0;
    end else if (RegWrite && Write_register != 5'd0) begin
      ref_q[Write_register] <= Write_data;
    end
  end

  // Output k: 0 = bypass port1, 1 = bypass port2, 2 = no-bypass port1, 3 = no-bypass port2.
  function automatic logic [31:0] obs(input int k);
    case (k)
      0: return b_rd1;
      1: return b_rd2;
      2: return n_rd1;
      default: return n_rd2;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    logic [4:0] a;
    a = (k % 2 == 0) ? Read_register_1 : Read_register_2;
    if (a == 5'd0) return 32'h0;
    if (k < 2 && RegWrite && !reset && Write_register == a) return Write_data;
    return ref_q[a];
  endfunction

  // Apply one cycle's inputs just after the falling edge; outputs settle before the next rise.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    reset = r; RegWrite = we; Write_register = wa; Write_data = wd;
    Read_register_1 = a1; Read_register_2 = a2;
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] e [4];
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 5);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== 32'h0) begin
        errors++; $display("FAIL reset_0_5 out%0d got %h exp %h", k, obs(k), 32'h0);
      end
    end
    drive(0, 0, 0, 0, 28, 29);
    e = '{GP, SP, GP, SP};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== e[k]) begin
        errors++; $display("FAIL reset_28_29 out%0d got %h exp %h", k, obs(k), e[k]);
      end
    end
  endtask

  task automatic test_write_read;
    drive(0, 1, 8, 32'hDEAD_BEEF, 1, 2);
    drive(0, 0, 0, 0, 8, 8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL write_read out%0d got %h exp %h", k, obs(k), 32'hDEAD_BEEF);
      end
    end
    // Every other register must still hold its reset value.
    for (int a = 0; a < 32; a++) begin
      logic [31:0] e;
      e = (a == 8) ? 32'hDEAD_BEEF : (a == 28) ? GP : (a == 29) ? SP : 32'h0;
      drive(0, 0, 0, 0, 5'(a), 5'(31 - a));
      checks++;
      if (b_rd1 !== e || n_rd1 !== e) begin
        errors++; $display("FAIL scan r%0d got %h/%h exp %h", a, b_rd1, n_rd1, e);
      end
    end
  endtask

  task automatic test_zero;
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== 32'h0) begin
        errors++; $display("FAIL zero_same out%0d got %h exp %h", k, obs(k), 32'h0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== 32'h0) begin
        errors++; $display("FAIL zero_next out%0d got %h exp %h", k, obs(k), 32'h0);
      end
    end
  endtask

  task automatic test_bypass;
    drive(0, 1, 9, 32'h1111_1111, 0, 0);
    drive(0, 1, 9, 32'h2222_2222, 9, 3);
    checks++;
    if (b_rd1 !== 32'h2222_2222) begin
      errors++; $display("FAIL bypass_on got %h exp %h", b_rd1, 32'h2222_2222);
    end
    checks++;
    if (n_rd1 !== 32'h1111_1111) begin
      errors++; $display("FAIL bypass_off_before got %h exp %h", n_rd1, 32'h1111_1111);
    end
    drive(0, 0, 0, 0, 9, 9);
    checks++;
    if (n_rd1 !== 32'h2222_2222 || b_rd2 !== 32'h2222_2222) begin
      errors++; $display("FAIL bypass_after got %h/%h exp %h", n_rd1, b_rd2, 32'h2222_2222);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v [3];
    v = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    drive(0, 1, 10, 32'h5555_0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] prev;
      prev = (i == 0) ? 32'h5555_0000 : v[i-1];
      drive(0, 1, 10, v[i], 10, 10);
      checks++;
      if (b_rd1 !== v[i] || b_rd2 !== v[i]) begin
        errors++; $display("FAIL b2b_bypass[%0d] got %h/%h exp %h", i, b_rd1, b_rd2, v[i]);
      end
      checks++;
      if (n_rd1 !== prev || n_rd2 !== prev) begin
        errors++; $display("FAIL b2b_stored[%0d] got %h/%h exp %h", i, n_rd1, n_rd2, prev);
      end
    end
    drive(0, 0, 0, 0, 10, 10);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== v[2]) begin
        errors++; $display("FAIL b2b_final out%0d got %h exp %h", k, obs(k), v[2]);
      end
    end
  endtask

  task automatic test_reset_priority;
    drive(0, 1, 29, 32'hCAFE_0029, 0, 0);
    drive(1, 1, 29, 32'h1234_5678, 29, 29);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs(k) !== 32'hCAFE_0029) begin
        errors++; $display("FAIL rst_no_fwd out%0d got %h exp %h", k, obs(k), 32'hCAFE_0029);
      end
    end
    drive(0, 0, 0, 0, 29, 28);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = (k % 2 == 0) ? SP : GP;
      checks++;
      if (obs(k) !== e) begin
        errors++; $display("FAIL rst_priority out%0d got %h exp %h", k, obs(k), e);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 10000; n++) begin
      logic r, we;
      logic [4:0] wa, a1, a2;
      r  = ($urandom_range(0, 499) == 0);
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? wa : ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? wa : ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      drive(r, we, wa, $urandom, a1, a2);
      for (int k = 0; k < 4; k++) begin
        logic [31:0] e;
        e = exp_rd(k);
        checks++;
        if (obs(k) !== e) begin
          errors++;
          if (errors < 20) $display("FAIL random[%0d] out%0d got %h exp %h", n, k, obs(k), e);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_zero;
    test_bypass;
    test_back_to_back;
    test_reset_priority;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
